// File: rtl/wta_epoch_controller.sv
// -----------------------------------------------------------------------------
// wta_epoch_controller
//
// Sequencer for a clocked-STDP winner-take-all layer. One input sample is
// accepted per start handshake. The controller then:
//   1. runs the layer time counter across one gamma cycle (INTEG),
//   2. latches the first neuron to spike as the winner and drives lateral
//      inhibition for every other neuron,
//   3. holds the STDP weight-update window (LEARN, only when learning and a
//      winner exists),
//   4. holds the membrane reset / refractory window (REST),
//   5. pulses done for one cycle with the result (DONE).
//
// Handshake: start is a valid strobe qualified by ready. A sample is accepted
// on a rising edge where ready=1 and start=1. start in any other cycle is
// dropped, not queued. ready is high only in IDLE.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   start, learn   sample valid and its learn flag (sampled together)
//   ready          controller idle, start will be accepted
//   spike_volley   column output spikes for the current time_val
//   time_val       integration time broadcast to the column
//   integrate      column integration enable
//   inhibit        lateral inhibition mask (bit i=1 suppresses neuron i)
//   stdp_en        weight-update enable
//   neuron_rst     membrane clear
//   winner         latched winner index, all-ones when there is no winner
//   winner_time    time_val at which the winner spiked, 0 when none
//   done           one-cycle result strobe
//   fsm_state      current controller state, for observation only
//
// Every output is a flop. The next-state process computes the next value of
// each output, and the register process stores it.
// -----------------------------------------------------------------------------
module wta_epoch_controller #(
  parameter int NEURONS     = 16,
  parameter int WIN_W       = 5,
  parameter int TIME_W      = 4,
  parameter int TEST_PERIOD = 8,
  parameter int GAMMA       = 16,
  parameter int STDP_CYCLES = 2,
  parameter int REST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               learn,
  output logic               ready,
  input  logic [NEURONS-1:0] spike_volley,
  output logic [TIME_W-1:0]  time_val,
  output logic               integrate,
  output logic [NEURONS-1:0] inhibit,
  output logic               stdp_en,
  output logic               neuron_rst,
  output logic [WIN_W-1:0]   winner,
  output logic [TIME_W-1:0]  winner_time,
  output logic               done,
  output logic [2:0]         fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTEG = 3'd1,
    S_LEARN = 3'd2,
    S_REST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                CNT_W    = 8;
  localparam logic [WIN_W-1:0]  NO_WIN   = '1;
  localparam logic [TIME_W-1:0] LAST_T   = TIME_W'(GAMMA - 1);
  localparam logic [CNT_W-1:0]  STDP_END = CNT_W'(STDP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REST_END = CNT_W'(REST_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               learn_q, learn_d;
  logic [TIME_W-1:0]  time_d;
  logic [WIN_W-1:0]   winner_d;
  logic [TIME_W-1:0]  winner_time_d;
  logic [NEURONS-1:0] inhibit_d;

  // Highest set index of the volley. Ties go to the highest index, so a
  // plain ascending scan where later hits overwrite earlier ones is enough.
  logic [WIN_W-1:0]   pick;
  logic [NEURONS-1:0] pick_mask;
  logic               in_window;

  always_comb begin
    pick = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (spike_volley[i]) pick = WIN_W'(i);
    end
  end

  always_comb begin
    pick_mask = '1;
    for (int i = 0; i < NEURONS; i++) begin
      if (pick == WIN_W'(i)) pick_mask[i] = 1'b0;
    end
  end

  // Only time values 0..TEST_PERIOD-1 may produce a winner.
  assign in_window = ({{(32-TIME_W){1'b0}}, time_val} < TEST_PERIOD);

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    learn_d       = learn_q;
    time_d        = time_val;
    winner_d      = winner;
    winner_time_d = winner_time;
    inhibit_d     = inhibit;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_INTEG;
          learn_d       = learn;
          time_d        = '0;
          winner_d      = NO_WIN;
          winner_time_d = '0;
          inhibit_d     = '0;
        end
      end

      S_INTEG: begin
        // The first qualifying volley freezes the winner. Later spikes are
        // ignored because the winner is no longer all-ones.
        if (winner == NO_WIN && in_window && spike_volley != '0) begin
          winner_d      = pick;
          winner_time_d = time_val;
          inhibit_d     = pick_mask;
        end
        if (time_val == LAST_T) begin
          // time_val holds GAMMA-1 from here until the next start.
          cnt_d = '0;
          // Use winner_d so a latch on the final cycle still counts.
          if (learn_q && winner_d != NO_WIN) state_d = S_LEARN;
          else                               state_d = S_REST;
        end else begin
          time_d = time_val + 1'b1;
        end
      end

      S_LEARN: begin
        if (cnt_q == STDP_END) begin
          cnt_d   = '0;
          state_d = S_REST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REST: begin
        if (cnt_q == REST_END) begin
          cnt_d     = '0;
          state_d   = S_DONE;
          inhibit_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Enables are registered decodes of the
  // next state, so each one is high exactly while the FSM sits in its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      learn_q     <= 1'b0;
      time_val    <= '0;
      winner      <= NO_WIN;
      winner_time <= '0;
      inhibit     <= '0;
      ready       <= 1'b1;
      integrate   <= 1'b0;
      stdp_en     <= 1'b0;
      neuron_rst  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      learn_q     <= learn_d;
      time_val    <= time_d;
      winner      <= winner_d;
      winner_time <= winner_time_d;
      inhibit     <= inhibit_d;
      ready       <= (state_d == S_IDLE);
      integrate   <= (state_d == S_INTEG);
      stdp_en     <= (state_d == S_LEARN);
      neuron_rst  <= (state_d == S_REST);
      done        <= (state_d == S_DONE);
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_wta_epoch_controller.sv
// -----------------------------------------------------------------------------
// Bench for wta_epoch_controller. Each epoch pushes its expected
// {winner, winner_time} onto exp_q when start is driven. The entry is popped
// and compared when done is seen. Outputs are sampled 1 ns after the rising
// edge, and inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_wta_epoch_controller;

  localparam int N  = 16;
  localparam int WW = 5;
  localparam int TW = 4;
  localparam logic [WW-1:0] NONE = 5'h1f;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          learn;
  logic          ready;
  logic [N-1:0]  spike_volley;
  logic [TW-1:0] time_val;
  logic          integrate;
  logic [N-1:0]  inhibit;
  logic          stdp_en;
  logic          neuron_rst;
  logic [WW-1:0] winner;
  logic [TW-1:0] winner_time;
  logic          done;
  logic [2:0]    fsm_state;

  wta_epoch_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .learn        (learn),
    .ready        (ready),
    .spike_volley (spike_volley),
    .time_val     (time_val),
    .integrate    (integrate),
    .inhibit      (inhibit),
    .stdp_en      (stdp_en),
    .neuron_rst   (neuron_rst),
    .winner       (winner),
    .winner_time  (winner_time),
    .done         (done),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  logic [WW+TW-1:0] exp_q[$];
  logic [N-1:0]     sched[16];

  task automatic clear_sched();
    for (int i = 0; i < 16; i++) sched[i] = '0;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (ready !== 1'b1) begin
      $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; learn = 1'b0; spike_volley = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({ready, integrate, stdp_en, neuron_rst, done} !== 5'b10000 ||
        time_val !== 4'd0 || inhibit !== 16'h0 ||
        winner !== NONE || winner_time !== 4'd0) begin
      $display("FAIL reset_values: rdy=%b int=%b stdp=%b nrst=%b done=%b t=%0d inh=%h win=%h wt=%0d",
               ready, integrate, stdp_en, neuron_rst, done, time_val, inhibit, winner, winner_time);
      miscompares++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || integrate !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_release_idle: rdy=%b int=%b done=%b required 1 0 0", ready, integrate, done);
      miscompares++;
    end
  endtask

  // Runs one sample through the controller and checks the whole epoch.
  task automatic run_epoch(input logic lrn, input logic [WW-1:0] ew, input logic [TW-1:0] et,
                           input int elat, input int estdp, input string name);
    int cyc;
    int n_stdp;
    int n_rst;
    logic got;
    logic [WW+TW-1:0] exp;
    logic [N-1:0] mask;
    mask = '0;
    if (ew != NONE) mask = ~(16'h0001 << ew);
    wait_ready(name);
    start = 1'b1; learn = lrn;
    exp_q.push_back({ew, et});
    @(posedge clk); #1;
    start = 1'b0; learn = 1'b0;
    n_stdp = 0; n_rst = 0; got = 1'b0;
    for (cyc = 1; cyc <= 60 && !got; cyc++) begin
      spike_volley = (integrate === 1'b1) ? sched[time_val] : '0;
      if (cyc == 1) begin
        vectors++;
        if (integrate !== 1'b1 || time_val !== 4'd0 || ready !== 1'b0) begin
          $display("FAIL %s first_integ: int=%b t=%0d rdy=%b required 1 0 0", name, integrate, time_val, ready);
          miscompares++;
        end
      end
      if (ew != NONE && cyc == int'(et) + 1) begin
        vectors++;
        if (inhibit !== 16'h0) begin
          $display("FAIL %s inhibit_before_latch: got %h required 0000", name, inhibit);
          miscompares++;
        end
      end
      if (ew != NONE && cyc == int'(et) + 2) begin
        vectors++;
        if (inhibit !== mask || winner !== ew) begin
          $display("FAIL %s latch_next_cycle: inh=%h win=%0d required %h %0d", name, inhibit, winner, mask, ew);
          miscompares++;
        end
      end
      if (stdp_en === 1'b1) n_stdp++;
      if (neuron_rst === 1'b1) begin
        n_rst++;
        if (n_rst == 2) begin
          vectors++;
          if (inhibit !== mask) begin
            $display("FAIL %s inhibit_end_rest: got %h required %h", name, inhibit, mask);
            miscompares++;
          end
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (cyc != elat) begin
          $display("FAIL %s done_latency: got %0d required %0d", name, cyc, elat);
          miscompares++;
        end
        vectors++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s result: done with empty expected queue", name);
          miscompares++;
        end else begin
          exp = exp_q.pop_front();
          if ({winner, winner_time} !== exp) begin
            $display("FAIL %s result: win=%0d wt=%0d required win=%0d wt=%0d",
                     name, winner, winner_time, exp[WW+TW-1:TW], exp[TW-1:0]);
            miscompares++;
          end
        end
        vectors++;
        if (n_stdp != estdp || n_rst != 2 || inhibit !== 16'h0) begin
          $display("FAIL %s windows: stdp=%0d nrst=%0d inh=%h required %0d 2 0000", name, n_stdp, n_rst, inhibit, estdp);
          miscompares++;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    spike_volley = '0;
    if (!got) begin
      vectors++;
      $display("FAIL %s done_timeout: no done within 60 cycles", name);
      miscompares++;
      void'(exp_q.pop_front());
    end else begin
      @(posedge clk); #1;
      vectors++;
      if (ready !== 1'b1 || done !== 1'b0 || {winner, winner_time} !== {ew, et}) begin
        $display("FAIL %s after_done: rdy=%b done=%b win=%0d wt=%0d required 1 0 %0d %0d",
                 name, ready, done, winner, winner_time, ew, et);
        miscompares++;
      end
    end
  endtask

  task automatic test_learn_single();
    clear_sched(); sched[3] = 16'h0008;
    run_epoch(1'b1, 5'd3, 4'd3, 21, 2, "learn_single");
  endtask

  task automatic test_tie_and_freeze();
    clear_sched(); sched[0] = 16'h0201; sched[4] = 16'h8000;
    run_epoch(1'b1, 5'd9, 4'd0, 21, 2, "tie_freeze");
  endtask

  task automatic test_late_spike();
    clear_sched(); sched[8] = 16'h0001;
    run_epoch(1'b1, NONE, 4'd0, 19, 0, "late_spike");
  endtask

  task automatic test_last_window();
    clear_sched(); sched[7] = 16'h0002;
    run_epoch(1'b0, 5'd1, 4'd7, 19, 0, "last_window");
  endtask

  task automatic test_inference();
    clear_sched(); sched[2] = 16'h0010;
    run_epoch(1'b0, 5'd4, 4'd2, 19, 0, "inference");
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int n;
      int t;
      logic l;
      logic win_ok;
      n = $urandom_range(0, 15);
      t = $urandom_range(0, 15);
      l = 1'($urandom_range(0, 1));
      win_ok = (t < 8);
      clear_sched(); sched[t] = 16'h0001 << n;
      run_epoch(l, win_ok ? WW'(n) : NONE, win_ok ? TW'(t) : 4'd0,
                (l && win_ok) ? 21 : 19, (l && win_ok) ? 2 : 0, "random");
    end
  endtask

  task automatic test_reset_mid_integ();
    logic hit;
    clear_sched(); sched[1] = 16'h0020;
    wait_ready("reset_mid");
    start = 1'b1; learn = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; learn = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      spike_volley = (integrate === 1'b1) ? sched[time_val] : '0;
      if (time_val === 4'd5 && integrate === 1'b1) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    spike_volley = '0;
    vectors++;
    if (!hit || winner !== 5'd5) begin
      $display("FAIL reset_mid pre_reset: hit=%b win=%0d required 1 5", hit, winner);
      miscompares++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (winner !== NONE || ready !== 1'b1 || integrate !== 1'b0 || stdp_en !== 1'b0 ||
        neuron_rst !== 1'b0 || done !== 1'b0 || inhibit !== 16'h0 || time_val !== 4'd0 ||
        winner_time !== 4'd0) begin
      $display("FAIL reset_mid abort: win=%h rdy=%b int=%b stdp=%b nrst=%b done=%b inh=%h t=%0d",
               winner, ready, integrate, stdp_en, neuron_rst, done, inhibit, time_val);
      miscompares++;
    end
    hit = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || ready !== 1'b1) hit = 1'b1;
    end
    vectors++;
    if (hit) begin
      $display("FAIL reset_mid no_done: spurious done or ready drop seen=%b required 0", hit);
      miscompares++;
    end
  endtask

  // start held high: one sample per done, restart right after ready returns.
  task automatic test_back_to_back();
    int dones;
    logic [WW+TW-1:0] exp;
    clear_sched();
    wait_ready("back_to_back");
    start = 1'b1; learn = 1'b0;
    exp_q.push_back({NONE, 4'd0});
    exp_q.push_back({NONE, 4'd0});
    dones = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        vectors++;
        if (cyc != 19 * dones + (dones - 1)) begin
          $display("FAIL back_to_back done_cycle: got %0d required %0d", cyc, 19 * dones + (dones - 1));
          miscompares++;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        vectors++;
        if ({winner, winner_time} !== exp) begin
          $display("FAIL back_to_back result: got %h required %h", {winner, winner_time}, exp);
          miscompares++;
        end
      end
      if (cyc == 20) begin
        vectors++;
        if (ready !== 1'b1 || integrate !== 1'b0) begin
          $display("FAIL back_to_back ready_return: rdy=%b int=%b required 1 0", ready, integrate);
          miscompares++;
        end
      end
      if (cyc == 21) begin
        vectors++;
        if (integrate !== 1'b1 || time_val !== 4'd0 || ready !== 1'b0) begin
          $display("FAIL back_to_back restart: int=%b t=%0d rdy=%b required 1 0 0", integrate, time_val, ready);
          miscompares++;
        end
      end
      if (cyc == 40) start = 1'b0;
    end
    vectors++;
    if (dones != 2 || exp_q.size() != 0) begin
      $display("FAIL back_to_back done_count: got %0d required 2 (left %0d)", dones, exp_q.size());
      miscompares++;
      exp_q.delete();
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || integrate !== 1'b0) begin
      $display("FAIL back_to_back idle_after: rdy=%b int=%b required 1 0", ready, integrate);
      miscompares++;
    end
  endtask

  initial begin
    clear_sched();
    test_reset();
    test_learn_single();
    test_tie_and_freeze();
    test_late_spike();
    test_last_window();
    test_inference();
    test_random();
    test_reset_mid_integ();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
